// File: rtl/berexp_lazy_compare_pkg.sv
// Shared types and constants for the BerExp lazy byte comparator.
// Holds the FSM state encoding and the z-preparation expression.
package berexp_pkg;

   localparam int ZW        = 64;
   localparam int BYTE_W    = 8;
   localparam int NUM_BYTES = ZW / BYTE_W;
   localparam int IDX_W     = 3;
   localparam int CNT_W     = 4;
   localparam int SHIFT_W   = 6;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMP  = 2'd1,
      DONE = 2'd2
   } berexp_state_t;

   // z = (2*exp - 1) >> s, wrapping modulo 2^ZW so exp=0 yields all ones.
   function automatic logic [ZW-1:0] prep_z(input logic [ZW-1:0] exp_val,
                                            input logic [SHIFT_W-1:0] shift);
      logic [ZW-1:0] twice_minus_one;
      twice_minus_one = {exp_val[ZW-2:0], 1'b0} - {{(ZW-1){1'b0}}, 1'b1};
      return twice_minus_one >> shift;
   endfunction

endpackage

// File: rtl/berexp_lazy_compare_if.sv
// Handshake bundle between ApproxExp, the PRNG byte port, the comparator
// and the sampler control.
interface berexp_lazy_compare_if;

   logic                              exp_val;
   logic                              exp_rdy;
   logic [berexp_pkg::ZW-1:0]         exp_i;
   logic [berexp_pkg::SHIFT_W-1:0]    s_i;

   logic                              rnd_val;
   logic                              rnd_rdy;
   logic [berexp_pkg::BYTE_W-1:0]     rnd_i;

   logic                              dout_val;
   logic                              dout_rdy;
   logic                              accept_o;
   logic [berexp_pkg::CNT_W-1:0]      bytes_used_o;

   modport master (
      output exp_val, exp_i, s_i, rnd_val, rnd_i, dout_rdy,
      input  exp_rdy, rnd_rdy, dout_val, accept_o, bytes_used_o
   );

   modport slave (
      input  exp_val, exp_i, s_i, rnd_val, rnd_i, dout_rdy,
      output exp_rdy, rnd_rdy, dout_val, accept_o, bytes_used_o
   );

endinterface

// File: rtl/berexp_lazy_compare.sv
// BerExp step of the Falcon sampler: compares z, MSB byte first, against
// random bytes and emits one accept/reject decision per exp input.
module berexp_lazy_compare
   import berexp_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   berexp_lazy_compare_if.slave  bus
);

   berexp_state_t        state_reg;
   logic [ZW-1:0]        z_reg;
   logic [IDX_W-1:0]     idx_reg;
   logic [CNT_W-1:0]     cnt_reg;
   logic                 accept_reg;
   logic                 exp_rdy_reg;
   logic                 rnd_rdy_reg;
   logic                 dout_val_reg;

   logic [BYTE_W-1:0]    z_bytes [NUM_BYTES];
   logic [BYTE_W-1:0]    zb;
   logic                 rnd_fire;
   logic                 rnd_lt;
   logic                 rnd_gt;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_BYTES; gi++) begin : g_zbyte
         assign z_bytes[gi] = z_reg[gi*BYTE_W +: BYTE_W];
      end
   endgenerate

   assign zb       = z_bytes[idx_reg];
   assign rnd_fire = bus.rnd_val && rnd_rdy_reg;
   assign rnd_lt   = bus.rnd_i < zb;
   assign rnd_gt   = bus.rnd_i > zb;

   // Handshake outputs are registered alongside the state so each one is
   // high exactly while the FSM sits in its owning state.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg    <= IDLE;
         z_reg        <= '0;
         idx_reg      <= '0;
         cnt_reg      <= '0;
         accept_reg   <= 1'b0;
         exp_rdy_reg  <= 1'b0;
         rnd_rdy_reg  <= 1'b0;
         dout_val_reg <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (bus.exp_val && exp_rdy_reg) begin
                  z_reg       <= prep_z(bus.exp_i, bus.s_i);
                  idx_reg     <= IDX_W'(NUM_BYTES - 1);
                  cnt_reg     <= '0;
                  state_reg   <= CMP;
                  exp_rdy_reg <= 1'b0;
                  rnd_rdy_reg <= 1'b1;
               end else begin
                  exp_rdy_reg <= 1'b1;
               end
            end

            CMP: begin
               if (rnd_fire) begin
                  cnt_reg <= cnt_reg + CNT_W'(1);
                  // Equality on the last byte means w == 0, which rejects.
                  if (rnd_lt || rnd_gt || (idx_reg == '0)) begin
                     accept_reg   <= rnd_lt;
                     state_reg    <= DONE;
                     rnd_rdy_reg  <= 1'b0;
                     dout_val_reg <= 1'b1;
                  end else begin
                     idx_reg <= idx_reg - IDX_W'(1);
                  end
               end
            end

            DONE: begin
               if (bus.dout_rdy) begin
                  state_reg    <= IDLE;
                  dout_val_reg <= 1'b0;
                  exp_rdy_reg  <= 1'b1;
               end
            end

            default: begin
               state_reg    <= IDLE;
               exp_rdy_reg  <= 1'b0;
               rnd_rdy_reg  <= 1'b0;
               dout_val_reg <= 1'b0;
            end
         endcase
      end
   end

   assign bus.exp_rdy      = exp_rdy_reg;
   assign bus.rnd_rdy      = rnd_rdy_reg;
   assign bus.dout_val     = dout_val_reg;
   assign bus.accept_o     = accept_reg;
   assign bus.bytes_used_o = cnt_reg;

endmodule

// File: tb/tb_berexp_lazy_compare.sv
// Scoreboard bench for berexp_lazy_compare: directed cases plus a random
// back-to-back run against a bench-side reference of the BerExp compare.
module tb_berexp_lazy_compare;

   logic clk;
   logic rst;

   berexp_lazy_compare_if bus_if ();

   berexp_lazy_compare dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic       acc;
      logic [3:0] used;
   } exp_t;

   exp_t       sb_q [$];
   logic [7:0] rnd_src [$];
   int         n_cmp;
   int         n_err;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present exp/s and wait (bounded) for the handshake edge to pass.
   task automatic drive_exp(input logic [63:0] e, input logic [5:0] s, output bit ok);
      ok = 1'b0;
      bus_if.exp_val = 1'b1;
      bus_if.exp_i   = e;
      bus_if.s_i     = s;
      for (int c = 0; c < 50; c++) begin
         if (bus_if.exp_rdy === 1'b1) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      tick();
      bus_if.exp_val = 1'b0;
   endtask

   // Feed bytes from rnd_src until dout_val; lat counts clocks after handshake.
   task automatic run_until_done(input bit toggle, output int lat, output bit ok);
      bit consumed;
      ok  = 1'b0;
      lat = 0;
      for (int c = 0; c < 100; c++) begin
         if (bus_if.dout_val === 1'b1) begin
            ok = 1'b1;
            break;
         end
         if (rnd_src.size() > 0 && (!toggle || (c % 2) == 0)) begin
            bus_if.rnd_val = 1'b1;
            bus_if.rnd_i   = rnd_src[0];
         end else begin
            bus_if.rnd_val = 1'b0;
         end
         consumed = bus_if.rnd_val && (bus_if.rnd_rdy === 1'b1);
         tick();
         if (consumed) void'(rnd_src.pop_front());
         lat++;
      end
      bus_if.rnd_val = 1'b0;
   endtask

   task automatic finish_dout();
      bus_if.dout_rdy = 1'b1;
      tick();
      bus_if.dout_rdy = 1'b0;
   endtask

   // One directed decision: push expectation, run, compare at dout_val.
   task automatic one_decision(input string name, input logic [63:0] e, input logic [5:0] s,
                               input bit acc, input int used, input bit chk_lat);
      bit   ok_h, ok_d;
      int   lat;
      exp_t want;
      sb_q.push_back('{acc: acc, used: 4'(used)});
      drive_exp(e, s, ok_h);
      run_until_done(1'b0, lat, ok_d);
      want = sb_q.pop_front();
      n_cmp++;
      if (!(ok_h && ok_d)) begin
         n_err++;
         $display("FAIL %s_timeout: handshake=%0b done=%0b required 1/1", name, ok_h, ok_d);
      end
      n_cmp++;
      if (bus_if.accept_o !== want.acc) begin
         n_err++;
         $display("FAIL %s_accept: got %0b required %0b", name, bus_if.accept_o, want.acc);
      end
      n_cmp++;
      if (bus_if.bytes_used_o !== want.used) begin
         n_err++;
         $display("FAIL %s_bytes: got %0d required %0d", name, bus_if.bytes_used_o, want.used);
      end
      if (chk_lat) begin
         n_cmp++;
         if (lat != used) begin
            n_err++;
            $display("FAIL %s_latency: got %0d clocks required %0d", name, lat, used);
         end
      end
      $display("[%s] exp=%h s=%0d accept=%0b bytes=%0d lat=%0d", name, e, s,
               bus_if.accept_o, bus_if.bytes_used_o, lat);
      finish_dout();
      rnd_src.delete();
   endtask

   task automatic test_reset();
      rst = 1'b0;
      tick();
      tick();
      n_cmp++;
      if ({bus_if.dout_val, bus_if.accept_o, bus_if.bytes_used_o, bus_if.rnd_rdy, bus_if.exp_rdy} !== 8'b0) begin
         n_err++;
         $display("FAIL reset_outputs: dv=%b acc=%b bytes=%0d rr=%b er=%b required all 0",
                  bus_if.dout_val, bus_if.accept_o, bus_if.bytes_used_o, bus_if.rnd_rdy, bus_if.exp_rdy);
      end
      rst = 1'b1;
      tick();
      n_cmp++;
      if (bus_if.exp_rdy !== 1'b1) begin
         n_err++;
         $display("FAIL reset_exp_rdy: got %b required 1", bus_if.exp_rdy);
      end
      $display("[reset] exp_rdy=%b after release", bus_if.exp_rdy);
   endtask

   task automatic test_basic();
      rnd_src = '{8'h00};
      one_decision("accept_1b", 64'h4000_0000_0000_0000, 6'd0, 1'b1, 1, 1'b1);
      rnd_src = '{8'h80};
      one_decision("reject_1b", 64'h4000_0000_0000_0000, 6'd0, 1'b0, 1, 1'b1);
      rnd_src = '{8'h7F, 8'hFE};
      one_decision("accept_2b", 64'h4000_0000_0000_0000, 6'd0, 1'b1, 2, 1'b1);
      rnd_src = '{8'h01};
      one_decision("s63_zero", 64'h4000_0000_0000_0000, 6'd63, 1'b0, 1, 1'b1);
   endtask

   task automatic test_all_equal();
      bit ok_h, ok_d;
      int lat;
      exp_t want;
      for (int i = 0; i < 9; i++) rnd_src.push_back(8'hFF);
      sb_q.push_back('{acc: 1'b0, used: 4'd8});
      drive_exp(64'h0, 6'd0, ok_h);
      run_until_done(1'b0, lat, ok_d);
      want = sb_q.pop_front();
      n_cmp++;
      if (!(ok_h && ok_d) || bus_if.accept_o !== want.acc || bus_if.bytes_used_o !== want.used) begin
         n_err++;
         $display("FAIL all_equal: ok=%0b acc=%b bytes=%0d required acc=0 bytes=8",
                  ok_h && ok_d, bus_if.accept_o, bus_if.bytes_used_o);
      end
      bus_if.rnd_val = 1'b1;
      bus_if.rnd_i   = 8'hFF;
      tick();
      n_cmp++;
      if (bus_if.rnd_rdy !== 1'b0 || rnd_src.size() != 1 || bus_if.bytes_used_o !== 4'd8) begin
         n_err++;
         $display("FAIL ninth_byte: rnd_rdy=%b left=%0d bytes=%0d required 0/1/8",
                  bus_if.rnd_rdy, rnd_src.size(), bus_if.bytes_used_o);
      end
      bus_if.rnd_val = 1'b0;
      $display("[all_equal] accept=%b bytes=%0d lat=%0d", bus_if.accept_o, bus_if.bytes_used_o, lat);
      finish_dout();
      rnd_src.delete();
   endtask

   task automatic test_backpressure();
      bit ok_h, ok_d;
      int lat;
      exp_t want;
      rnd_src = '{8'h7F, 8'hFF, 8'h00};
      sb_q.push_back('{acc: 1'b1, used: 4'd3});
      drive_exp(64'h4000_0000_0000_0000, 6'd0, ok_h);
      // A stray exp offer during CMP must be ignored.
      bus_if.exp_val = 1'b1;
      bus_if.exp_i   = 64'h0;
      run_until_done(1'b1, lat, ok_d);
      bus_if.exp_val = 1'b0;
      want = sb_q.pop_front();
      n_cmp++;
      if (!(ok_h && ok_d) || lat <= 3) begin
         n_err++;
         $display("FAIL bp_stall: ok=%0b lat=%0d required ok=1 lat>3", ok_h && ok_d, lat);
      end
      for (int c = 0; c < 5; c++) begin
         n_cmp++;
         if (bus_if.dout_val !== 1'b1 || bus_if.accept_o !== want.acc ||
             bus_if.bytes_used_o !== want.used || bus_if.exp_rdy !== 1'b0) begin
            n_err++;
            $display("FAIL bp_hold%0d: dv=%b acc=%b bytes=%0d er=%b required 1/%b/%0d/0",
                     c, bus_if.dout_val, bus_if.accept_o, bus_if.bytes_used_o,
                     bus_if.exp_rdy, want.acc, want.used);
         end
         tick();
      end
      finish_dout();
      n_cmp++;
      if (bus_if.exp_rdy !== 1'b1 || bus_if.dout_val !== 1'b0) begin
         n_err++;
         $display("FAIL bp_release: er=%b dv=%b required 1/0", bus_if.exp_rdy, bus_if.dout_val);
      end
      $display("[backpressure] accept=%b bytes=%0d lat=%0d", want.acc, want.used, lat);
      rnd_src.delete();
   endtask

   task automatic test_reset_mid();
      bit ok_h;
      drive_exp(64'h0, 6'd0, ok_h);
      bus_if.rnd_val = 1'b1;
      bus_if.rnd_i   = 8'hFF;
      repeat (3) tick();
      bus_if.rnd_val = 1'b0;
      rst = 1'b0;
      tick();
      n_cmp++;
      if (!ok_h || bus_if.dout_val !== 1'b0 || bus_if.rnd_rdy !== 1'b0) begin
         n_err++;
         $display("FAIL midreset_abort: ok=%0b dv=%b rr=%b required 1/0/0",
                  ok_h, bus_if.dout_val, bus_if.rnd_rdy);
      end
      rst = 1'b1;
      tick();
      n_cmp++;
      if (bus_if.exp_rdy !== 1'b1) begin
         n_err++;
         $display("FAIL midreset_exp_rdy: got %b required 1", bus_if.exp_rdy);
      end
      $display("[reset_mid] aborted, exp_rdy=%b", bus_if.exp_rdy);
      rnd_src = '{8'h00};
      one_decision("post_reset", 64'h4000_0000_0000_0000, 6'd0, 1'b1, 1, 1'b1);
   endtask

   task automatic test_back_to_back();
      for (int t = 0; t < 20; t++) begin
         logic [63:0] e, z;
         logic [5:0]  s;
         logic [7:0]  b, zb;
         bit          acc;
         int          used;
         string       nm;
         e = {$urandom(), $urandom()};
         s = 6'($urandom_range(0, 63));
         z = ((e << 1) - 64'd1) >> s;
         acc  = 1'b0;
         used = 0;
         for (int j = 0; j < 8; j++) begin
            zb = z[8*(7-j) +: 8];
            b  = ($urandom_range(0, 2) != 0) ? zb : 8'($urandom());
            rnd_src.push_back(b);
            if (used == 0) begin
               if (b < zb) begin
                  acc = 1'b1; used = j + 1;
               end else if (b > zb || j == 7) begin
                  acc = 1'b0; used = j + 1;
               end
            end
         end
         nm = $sformatf("rand%0d", t);
         one_decision(nm, e, s, acc, used, 1'b1);
      end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst = 1'b0;
      bus_if.exp_val  = 1'b0;
      bus_if.exp_i    = '0;
      bus_if.s_i      = '0;
      bus_if.rnd_val  = 1'b0;
      bus_if.rnd_i    = '0;
      bus_if.dout_rdy = 1'b0;
      test_reset();
      test_basic();
      test_all_equal();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
